btb_assoc_predictor: RTL and testbench

BTB_ASSOC_PREDICTOR -- requirements
Module: btb_assoc_predictor

---
 rtl/btb_assoc_predictor.sv | 260 ++++++++++++++++++++++++++
 tb/tb_btb_assoc_predictor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc_predictor.sv
// btb_assoc_predictor
//   Set-associative branch target buffer with per-entry saturating direction
//   counters and a tree pseudo-LRU per set.
//
// Ports
//   clk                  single clock, all state changes on its rising edge
//   reset                asynchronous, active-high
//   flush                one-cycle pulse, invalidates the whole table
//   ready                high when the table is usable (FSM in READY)
//   pred_pc              fetch PC looked up combinationally
//   pred_hit/taken/target prediction result for pred_pc
//   upd_valid/pc/taken/target resolved-branch update
//
// Handshake: an update is accepted in any cycle where upd_valid & ready &
// ~flush; there is no back-pressure, so an update offered while not ready is
// simply dropped. An accepted update is held one cycle in stage U and written
// at the following edge, so it becomes visible two edges after it was offered.
//
// PC mapping: index = pc[INDEX_BITS+1:2], tag = pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];
// TAG_BITS + INDEX_BITS + 2 must not exceed 32.
module btb_assoc_predictor #(
  parameter int ASSOCIATIVITY = 4,
  parameter int SET_NUM       = 16,
  parameter int COUNTER_BITS  = 2,
  parameter int TAG_BITS      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  output logic        ready,
  input  logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int INDEX_BITS = $clog2(SET_NUM);
  localparam int WAY_BITS   = $clog2(ASSOCIATIVITY);
  localparam int PLRU_BITS  = ASSOCIATIVITY - 1;
  localparam int TAG_LSB    = INDEX_BITS + 2;
  localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  localparam logic [INDEX_BITS-1:0]   LAST_SET = INDEX_BITS'(SET_NUM - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   sweep_q, sweep_d;

  logic                    u_valid_q, u_valid_d;
  logic                    u_taken_q, u_taken_d;
  logic [INDEX_BITS-1:0]   u_idx_q, u_idx_d;
  logic [TAG_BITS-1:0]     u_tag_q, u_tag_d;
  logic [31:0]             u_target_q, u_target_d;

  logic [ASSOCIATIVITY-1:0] valid_q  [SET_NUM];
  logic [ASSOCIATIVITY-1:0] valid_d  [SET_NUM];
  logic [PLRU_BITS-1:0]     plru_q   [SET_NUM];
  logic [PLRU_BITS-1:0]     plru_d   [SET_NUM];
  logic [TAG_BITS-1:0]      tag_q    [SET_NUM][ASSOCIATIVITY];
  logic [TAG_BITS-1:0]      tag_d    [SET_NUM][ASSOCIATIVITY];
  logic [31:0]              target_q [SET_NUM][ASSOCIATIVITY];
  logic [31:0]              target_d [SET_NUM][ASSOCIATIVITY];
  logic [COUNTER_BITS-1:0]  ctr_q    [SET_NUM][ASSOCIATIVITY];
  logic [COUNTER_BITS-1:0]  ctr_d    [SET_NUM][ASSOCIATIVITY];

  logic [INDEX_BITS-1:0] pred_idx;
  logic [TAG_BITS-1:0]   pred_tag;
  logic                  p_hit;
  logic [WAY_BITS-1:0]   p_way;
  logic                  u_hit;
  logic [WAY_BITS-1:0]   u_way;
  logic                  u_inv_found;
  logic [WAY_BITS-1:0]   u_inv_way;
  logic [WAY_BITS-1:0]   alloc_way;
  logic                  sweep_en;
  logic                  unused_pc_bits;

  // Tree nodes are heap-ordered (children of n are 2n+1, 2n+2); way MSB
  // selects at the root. A node bit points toward its LRU half (0 = lower).
  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] tree,
                                                       input logic [WAY_BITS-1:0]  way);
    logic [PLRU_BITS-1:0] t;
    int n;
    t = tree;
    n = 0;
    for (int l = WAY_BITS - 1; l >= 0; l--) begin
      for (int k = 0; k < PLRU_BITS; k++) begin
        if (k == n) t[k] = ~way[l];
      end
      n = 2 * n + 1 + int'(way[l]);
    end
    return t;
  endfunction

  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_BITS-1:0] tree);
    logic b;
    int n;
    n = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b = 1'b0;
      for (int k = 0; k < PLRU_BITS; k++) begin
        if (k == n) b = tree[k];
      end
      n = 2 * n + 1 + int'(b);
    end
    return WAY_BITS'(n - PLRU_BITS);
  endfunction

  assign pred_idx       = pred_pc[INDEX_BITS+1:2];
  assign pred_tag       = pred_pc[TAG_BITS+TAG_LSB-1:TAG_LSB];
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  // FSM: next state and sweep pointer
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      ST_INIT: begin
        if (flush) begin
          sweep_d = '0;
        end else if (sweep_q == LAST_SET) begin
          state_d = ST_READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + INDEX_BITS'(1);
        end
      end
      ST_READY: begin
        if (flush) begin
          state_d = ST_INIT;
          sweep_d = '0;
        end
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready    = (state_q == ST_READY);
    sweep_en = (state_q == ST_INIT) && !flush;
  end

  // Lookups; descending scan so the lowest matching way wins
  always_comb begin
    p_hit       = 1'b0;
    p_way       = '0;
    u_hit       = 1'b0;
    u_way       = '0;
    u_inv_found = 1'b0;
    u_inv_way   = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (valid_q[pred_idx][w] && (tag_q[pred_idx][w] == pred_tag)) begin
        p_hit = 1'b1;
        p_way = WAY_BITS'(w);
      end
      if (valid_q[u_idx_q][w] && (tag_q[u_idx_q][w] == u_tag_q)) begin
        u_hit = 1'b1;
        u_way = WAY_BITS'(w);
      end
      if (!valid_q[u_idx_q][w]) begin
        u_inv_found = 1'b1;
        u_inv_way   = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    pred_hit    = ready & p_hit;
    pred_target = pred_hit ? target_q[pred_idx][p_way] : '0;
    pred_taken  = pred_hit & ctr_q[pred_idx][p_way][COUNTER_BITS-1];
  end

  // Stage U capture; an update in a flush cycle is not accepted
  always_comb begin
    u_valid_d  = upd_valid & ready & ~flush;
    u_taken_d  = upd_taken;
    u_idx_d    = upd_pc[INDEX_BITS+1:2];
    u_tag_d    = upd_pc[TAG_BITS+TAG_LSB-1:TAG_LSB];
    u_target_d = upd_target;
  end

  // Table next state: sweep clear, then prediction touch, then stage-U write
  // (so a stage-U PLRU touch on the same set lands last).
  always_comb begin
    valid_d   = valid_q;
    plru_d    = plru_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    alloc_way = u_inv_found ? u_inv_way : plru_victim(plru_q[u_idx_q]);

    if (sweep_en) begin
      valid_d[sweep_q] = '0;
      plru_d[sweep_q]  = '0;
    end

    if (pred_hit && !flush) begin
      plru_d[pred_idx] = plru_touch(plru_d[pred_idx], p_way);
    end

    if (u_valid_q && !flush) begin
      if (u_hit) begin
        target_d[u_idx_q][u_way] = u_target_q;
        if (u_taken_q) begin
          if (ctr_q[u_idx_q][u_way] != CTR_MAX)
            ctr_d[u_idx_q][u_way] = ctr_q[u_idx_q][u_way] + COUNTER_BITS'(1);
        end else begin
          if (ctr_q[u_idx_q][u_way] != '0)
            ctr_d[u_idx_q][u_way] = ctr_q[u_idx_q][u_way] - COUNTER_BITS'(1);
        end
        plru_d[u_idx_q] = plru_touch(plru_d[u_idx_q], u_way);
      end else if (u_taken_q) begin
        valid_d[u_idx_q][alloc_way]  = 1'b1;
        tag_d[u_idx_q][alloc_way]    = u_tag_q;
        target_d[u_idx_q][alloc_way] = u_target_q;
        ctr_d[u_idx_q][alloc_way]    = CTR_WEAK;
        plru_d[u_idx_q]              = plru_touch(plru_d[u_idx_q], alloc_way);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      u_valid_q  <= 1'b0;
      u_taken_q  <= 1'b0;
      u_idx_q    <= '0;
      u_tag_q    <= '0;
      u_target_q <= '0;
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      u_valid_q  <= u_valid_d;
      u_taken_q  <= u_taken_d;
      u_idx_q    <= u_idx_d;
      u_tag_q    <= u_tag_d;
      u_target_q <= u_target_d;
      valid_q    <= valid_d;
      plru_q     <= plru_d;
    end
  end

  // Payload fields are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// tb_btb_assoc_predictor
//   Directed bench for btb_assoc_predictor with default parameters
//   (4 ways, 16 sets, 2-bit counters, 16-bit tags).
module tb_btb_assoc_predictor;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        ready;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] set5_pc  [5] = '{32'h0000_0054, 32'h0000_0094, 32'h0000_00D4,
                                32'h0000_0114, 32'h0000_0154};
  logic [31:0] set5_tgt [5] = '{32'h0000_A000, 32'h0000_A010, 32'h0000_A020,
                                32'h0000_A030, 32'h0000_A040};

  btb_assoc_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .ready      (ready),
    .pred_pc    (pred_pc),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present pc on the prediction port and compare all three outputs
  task automatic pred_chk(input string tag, input logic [31:0] pc, input logic hit,
                          input logic taken, input logic [31:0] tgt);
    pred_pc = pc;
    #1;
    check({tag, ".hit"},    {31'b0, pred_hit},   {31'b0, hit});
    check({tag, ".taken"},  {31'b0, pred_taken}, {31'b0, taken});
    check({tag, ".target"}, pred_target,         tgt);
  endtask

  // One-cycle update pulse; it is captured at the edge inside this task
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    pred_pc    = 32'h0000_1000;
    #1;
    check("rst.ready", {31'b0, ready}, 32'd0);
    pred_chk("rst.pred", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // INIT sweep after reset: ready rises on the 16th edge
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("init.ready.%0d", k), {31'b0, ready}, {31'b0, (k == 16)});
      if (k < 16) check($sformatf("init.hit.%0d", k), {31'b0, pred_hit}, 32'd0);
    end
    pred_chk("idle.a", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    pred_chk("idle.b", 32'h0000_0054, 1'b0, 1'b0, 32'h0);
    pred_chk("idle.c", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    pred_pc = 32'h0;

    // Taken allocate, 2-edge latency
    upd(32'h0000_1000, 1'b1, 32'h0000_2000);
    pred_chk("lat.early", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    tick();
    pred_chk("alloc", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);
    pred_pc = 32'h0;

    // Counter walk 10->01->00->00, then up and saturate at 11
    upd(32'h0000_1000, 1'b0, 32'h0000_2000);
    tick();
    pred_chk("nt1", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    pred_pc = 32'h0;
    upd(32'h0000_1000, 1'b0, 32'h0000_2000);
    tick();
    pred_chk("nt2", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    pred_pc = 32'h0;
    upd(32'h0000_1000, 1'b0, 32'h0000_2000);
    tick();
    pred_chk("nt3", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    pred_pc = 32'h0;
    upd(32'h0000_1000, 1'b1, 32'h0000_2100);
    tick();
    pred_chk("up01", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2100);
    pred_pc = 32'h0;
    upd(32'h0000_1000, 1'b1, 32'h0000_2200);
    tick();
    pred_chk("up10", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2200);
    pred_pc = 32'h0;
    upd(32'h0000_1000, 1'b1, 32'h0000_2200);
    upd(32'h0000_1000, 1'b1, 32'h0000_2200);
    upd(32'h0000_1000, 1'b0, 32'h0000_2300);
    tick();
    pred_chk("sat11", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2300);
    pred_pc = 32'h0;

    // Five distinct tags in set 5: fifth evicts way 0
    for (int i = 0; i < 5; i++) upd(set5_pc[i], 1'b1, set5_tgt[i]);
    tick();
    pred_chk("evict.0", set5_pc[0], 1'b0, 1'b0, 32'h0);
    for (int i = 1; i < 5; i++)
      pred_chk($sformatf("evict.%0d", i), set5_pc[i], 1'b1, 1'b1, set5_tgt[i]);
    pred_pc = 32'h0;

    // Not-taken miss does not allocate
    upd(32'h0000_3000, 1'b0, 32'h0000_4000);
    tick();
    pred_chk("ntmiss", 32'h0000_3000, 1'b0, 1'b0, 32'h0);
    pred_chk("ntmiss.keep", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2300);
    pred_pc = 32'h0;

    // Flush with a pending update and an update offered in the flush cycle
    upd_valid  = 1'b1;
    upd_pc     = 32'h0000_2008;
    upd_taken  = 1'b1;
    upd_target = 32'h0000_5000;
    tick();
    upd_pc     = 32'h0000_2000;
    upd_target = 32'h0000_5100;
    flush      = 1'b1;
    #1;
    check("flush.ready_pre", {31'b0, ready}, 32'd1);
    tick();
    flush      = 1'b0;
    upd_valid  = 1'b0;
    pred_pc    = 32'h0000_1000;
    check("flush.ready0", {31'b0, ready}, 32'd0);
    upd_pc     = 32'h0000_2108;
    upd_target = 32'h0000_6000;
    for (int k = 1; k <= 16; k++) begin
      upd_valid = (k == 3);
      tick();
      check($sformatf("flush.ready.%0d", k), {31'b0, ready}, {31'b0, (k == 16)});
      if (k < 16) check($sformatf("flush.hit.%0d", k), {31'b0, pred_hit}, 32'd0);
    end
    upd_valid = 1'b0;
    pred_chk("flush.old0", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    pred_chk("flush.old5", set5_pc[1], 1'b0, 1'b0, 32'h0);
    pred_chk("flush.pend", 32'h0000_2008, 1'b0, 1'b0, 32'h0);
    pred_chk("flush.same", 32'h0000_2000, 1'b0, 1'b0, 32'h0);
    pred_chk("flush.drop", 32'h0000_2108, 1'b0, 1'b0, 32'h0);
    pred_pc = 32'h0;

    upd(32'h0000_1000, 1'b1, 32'h0000_7000);
    tick();
    pred_chk("realloc", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_7000);

    // Asynchronous reset mid-cycle while a hit is showing
    #2;
    reset = 1'b1;
    #1;
    check("arst.ready", {31'b0, ready}, 32'd0);
    check("arst.hit", {31'b0, pred_hit}, 32'd0);
    check("arst.taken", {31'b0, pred_taken}, 32'd0);
    check("arst.target", pred_target, 32'h0);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    check("arst.ready16", {31'b0, ready}, 32'd1);
    pred_chk("arst.miss", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    pred_pc = 32'h0;

    // Flush during INIT restarts the sweep
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("restart.ready.%0d", k), {31'b0, ready}, {31'b0, (k == 16)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
